object_plotter: RTL and testbench

Pixel-writing stage that sits directly downstream of the game control FSM and upstream of the VGA adapter. On each `start` it erases one game object (bird or wall) at its old position in the background colour, then redraws it at its new position, emitting one pixel write per clock as `x`/`y`/`colour`/`plot`. Control sequences bird and wall redraws by issuing commands and waiting for `done`.

---
 rtl/flappy_pkg.sv | 16 +
 rtl/object_plotter_if.sv | 20 ++
 rtl/rect_scanner.sv | 29 ++
 rtl/object_plotter.sv | 80 ++++++++
 tb/tb_object_plotter.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// flappy_pkg: shared screen, object, colour constants and plotter state encoding.
// Ports: none (package).
package flappy_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int BIRD_W   = 4;
    localparam int BIRD_H   = 4;
    localparam int WALL_W   = 10;
    localparam int GAP_H    = 40;
    localparam logic OBJ_WALL = 1'b0;
    localparam logic OBJ_BIRD = 1'b1;
    localparam logic [2:0] BG_COLOUR   = 3'b000;
    localparam logic [2:0] BIRD_COLOUR = 3'b110;
    localparam logic [2:0] WALL_COLOUR = 3'b010;
    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} plot_state_t;
endpackage

// File: rtl/object_plotter_if.sv
// object_plotter_if: command and pixel bus between control FSM, plotter and VGA adapter.
// Ports: none; master drives start/obj/positions and sees pixel/status outputs, slave is the plotter.
interface object_plotter_if;
    logic       start;
    logic       obj;
    logic [7:0] old_x;
    logic [7:0] new_x;
    logic [6:0] old_y;
    logic [6:0] new_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    modport master (output start, obj, old_x, new_x, old_y, new_y,
                    input x, y, colour, plot, busy, done);
    modport slave  (input start, obj, old_x, new_x, old_y, new_y,
                    output x, y, colour, plot, busy, done);
endinterface

// File: rtl/rect_scanner.sv
// rect_scanner: row-major dx/dy scan of a runtime-sized rectangle.
// Ports: clk, reset (async high), clear (zero counters), en (advance), w/h (size),
//        dx/dy (current offset), last (current offset is the final pixel).
module rect_scanner (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic [3:0] w,
    input  logic [6:0] h,
    output logic [3:0] dx,
    output logic [6:0] dy,
    output logic       last
);
    logic row_end;
    assign row_end = dx == w - 4'd1;
    assign last    = row_end && dy == h - 7'd1;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            dx <= '0;
            dy <= '0;
        end else if (clear) begin
            dx <= '0;
            dy <= '0;
        end else if (en) begin
            dx <= row_end ? 4'd0 : dx + 4'd1;
            dy <= row_end ? dy + 7'd1 : dy;
        end
endmodule

// File: rtl/object_plotter.sv
// object_plotter: erases one object at its old position then redraws it at the new one, one pixel per clock.
// Ports: clk, reset (async high), bus (slave: start/obj/old_*/new_* in; x/y/colour/plot/busy/done out).
module object_plotter
    import flappy_pkg::*;
(
    input logic             clk,
    input logic             reset,
    object_plotter_if.slave bus
);
    plot_state_t state;
    logic        obj_q;
    logic [7:0]  ox, nx;
    logic [6:0]  oy, ny;
    logic [3:0]  dx;
    logic [6:0]  dy;
    logic        last, erase, scanning, clear, clip, in_gap;
    logic [7:0]  bx;
    logic [6:0]  by;
    logic [8:0]  px;
    logic [7:0]  py;
    logic [2:0]  pix_colour;
    assign erase    = state == S_ERASE;
    assign scanning = erase || state == S_DRAW;
    // Counters restart for every command and again between the erase and draw passes.
    assign clear    = state == S_IDLE || (erase && last);
    rect_scanner u_scan (
        .clk(clk), .reset(reset), .clear(clear), .en(scanning),
        .w(obj_q ? 4'(BIRD_W) : 4'(WALL_W)),
        .h(obj_q ? 7'(BIRD_H) : 7'(SCREEN_H)),
        .dx(dx), .dy(dy), .last(last)
    );
    assign bx = erase ? ox : nx;
    assign by = obj_q ? (erase ? oy : ny) : 7'd0;
    // Widened sums so off-screen pixels are detected instead of wrapping onto the screen.
    assign px = {1'b0, bx} + {5'd0, dx};
    assign py = {1'b0, by} + {1'b0, dy};
    assign clip = px >= 9'(SCREEN_W) || py >= 8'(SCREEN_H);
    assign in_gap = py >= {1'b0, ny} && py < {1'b0, ny} + 8'(GAP_H);
    assign pix_colour = erase ? BG_COLOUR : obj_q ? BIRD_COLOUR : in_gap ? BG_COLOUR : WALL_COLOUR;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= S_IDLE;
            obj_q      <= OBJ_WALL;
            ox         <= '0;
            nx         <= '0;
            oy         <= '0;
            ny         <= '0;
            bus.x      <= '0;
            bus.y      <= '0;
            bus.colour <= '0;
            bus.plot   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.plot <= 1'b0;
            bus.done <= 1'b0;
            bus.busy <= scanning;
            case (state)
                S_IDLE: if (bus.start) begin
                    obj_q <= bus.obj;
                    ox    <= bus.old_x;
                    nx    <= bus.new_x;
                    oy    <= bus.old_y;
                    ny    <= bus.new_y;
                    state <= S_ERASE;
                end
                S_ERASE, S_DRAW: begin
                    bus.x      <= px[7:0];
                    bus.y      <= py[6:0];
                    bus.colour <= pix_colour;
                    bus.plot   <= ~clip;
                    if (last) state <= erase ? S_DRAW : S_DONE;
                end
                default: begin
                    bus.done <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_object_plotter.sv
// tb_object_plotter: table-driven command vectors with a pixel scoreboard, plus busy-start and reset sequences.
module tb_object_plotter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;

    object_plotter_if bus ();
    object_plotter dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;
    pix_t sb[$];

    typedef struct {
        bit obj;
        int ox, oy, nx, ny;
        int erase_plots, draw_plots;
    } cmd_t;
    cmd_t vec[6];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic void push_phase(bit o, int bx, int by, int gy, bit draw);
        int w = o ? 4 : 10;
        int h = o ? 4 : 120;
        pix_t e;
        if (!o) by = 0;
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++) begin
                int px = bx + i;
                int py = by + j;
                e.p = px < 160 && py < 120;
                e.x = 8'(px);
                e.y = 7'(py);
                e.c = !draw ? 3'b000 : o ? 3'b110 : (py >= gy && py < gy + 40) ? 3'b000 : 3'b010;
                sb.push_back(e);
            end
    endfunction

    // Issues one command; busy_at>0 pulses start at that cycle, rst_at>0 resets at that cycle.
    task automatic run_cmd(input cmd_t c, input int busy_at, input int rst_at);
        int n = c.obj ? 16 : 1200;
        int plots_e = 0;
        int plots_d = 0;
        pix_t e;
        sb.delete();
        push_phase(c.obj, c.ox, c.oy, c.ny, 1'b0);
        push_phase(c.obj, c.nx, c.ny, c.ny, 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.obj   = c.obj;
        bus.old_x = 8'(c.ox);
        bus.old_y = 7'(c.oy);
        bus.new_x = 8'(c.nx);
        bus.new_y = 7'(c.ny);
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("idle_busy_after_edge0", int'(bus.busy), 0);
        for (int k = 1; k <= 2 * n; k++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.plot !== e.p || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                (e.p && (bus.x !== e.x || bus.y !== e.y || bus.colour !== e.c))) begin
                errors++;
                $display("FAIL pixel cycle=%0d got x=%0d y=%0d col=%0d plot=%0d busy=%0d done=%0d exp x=%0d y=%0d col=%0d plot=%0d",
                         k, bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done, e.x, e.y, e.c, e.p);
            end
            if (bus.plot === 1'b1) begin
                if (k <= n) plots_e++;
                else plots_d++;
            end
            if (k == busy_at) begin
                bus.start = 1'b1;
                bus.obj   = ~c.obj;
                bus.new_x = 8'd0;
            end
            if (k == busy_at + 1) bus.start = 1'b0;
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                check("reset_plot", int'(bus.plot), 0);
                check("reset_busy", int'(bus.busy), 0);
                check("reset_done", int'(bus.done), 0);
                check("reset_x", int'(bus.x), 0);
                @(negedge clk);
                reset = 1'b0;
                sb.delete();
                return;
            end
        end
        @(posedge clk);
        #1;
        check("done_pulse", int'(bus.done), 1);
        check("busy_at_done", int'(bus.busy), 0);
        check("plot_at_done", int'(bus.plot), 0);
        check("erase_plots", plots_e, c.erase_plots);
        check("draw_plots", plots_d, c.draw_plots);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("done_single", int'(bus.done), 0);
            check("busy_after", int'(bus.busy), 0);
        end
    endtask

    initial begin
        cmd_t c;
        vec[0] = '{1'b1, 10, 22, 10, 20, 16, 16};
        vec[1] = '{1'b0, 50, 0, 49, 30, 1200, 1200};
        vec[2] = '{1'b0, 150, 0, 155, 100, 1200, 600};
        vec[3] = '{1'b1, 158, 118, 200, 126, 4, 0};
        vec[4] = '{1'b0, 2, 0, 250, 0, 1200, 0};
        vec[5] = '{1'b1, 0, 0, 156, 116, 16, 16};
        bus.start = 1'b0;
        bus.obj   = 1'b0;
        bus.old_x = '0;
        bus.old_y = '0;
        bus.new_x = '0;
        bus.new_y = '0;
        #1;
        check("rst_x", int'(bus.x), 0);
        check("rst_y", int'(bus.y), 0);
        check("rst_colour", int'(bus.colour), 0);
        check("rst_plot", int'(bus.plot), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) run_cmd(vec[i], 0, 0);
        run_cmd(vec[0], 5, 0);
        run_cmd(vec[1], 0, 10);
        c = '{1'b1, 40, 60, 41, 61, 16, 16};
        run_cmd(c, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
